// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and sizing helpers for the UART TX arbiter
package uart_arb_pkg;

    localparam int UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_e;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int uart_arb_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// rtl/uart_arb_rr.sv - combinational round-robin picker starting one slot after ptr
module uart_arb_rr
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = uart_arb_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_any
);

    localparam int SW = IDW + 1;

    logic [SW-1:0] slot;

    // Walk from the lowest-priority slot (ptr itself) towards ptr+1 so the
    // highest-priority hit is the one left standing after the loop.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        slot    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            slot = {1'b0, ptr} + SW'(k);
            if (slot >= SW'(NUM_REQ)) begin
                slot = slot - SW'(NUM_REQ);
            end
            if (req[slot[IDW-1:0]]) begin
                gnt_id  = slot[IDW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding uart_tx_v2; optional packet lock via UART_ARB_PKT_LOCK_EN
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DW-1:0]              tx_din,
    output logic                       tx_wr_en,
    input  logic                       tx_busy,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW = uart_arb_id_w(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    uart_arb_state_e      state_q;
    logic [DW-1:0]        tx_din_q;
    logic                 tx_wr_en_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 grant_valid_q;
    logic [IDW-1:0]       grant_id_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic                 lock_q;

    logic [NUM_REQ-1:0]   cand;
    logic [IDW-1:0]       pick_id;
    logic                 pick_any;
    logic [DW-1:0]        pick_data;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 lock_next;

    // While a packet owns the line only the owner may be picked.
    always_comb begin
        cand = req_valid;
        if (lock_q) begin
            cand = req_valid & (ONE_HOT0 << grant_id_q);
        end
    end

    uart_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req     (cand),
        .ptr     (rr_ptr_q),
        .gnt_id  (pick_id),
        .gnt_any (pick_any)
    );

    // Byte lane of the winning requester.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_data = req_data[i*DW +: DW];
            end
        end
    end

    assign pick_onehot = ONE_HOT0 << pick_id;

`ifdef UART_ARB_PKT_LOCK_EN
    // Keep ownership after any byte that does not close its packet.
    assign lock_next = ~req_last[pick_id];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign lock_next   = 1'b0;
`endif

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_din_q      <= '0;
            tx_wr_en_q    <= 1'b0;
            req_ready_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            lock_q        <= 1'b0;
        end else begin
            tx_wr_en_q  <= 1'b0;
            req_ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (!lock_q) begin
                        grant_valid_q <= 1'b0;
                    end
                    // A busy UART here is a character left over from before reset.
                    if (!tx_busy && pick_any) begin
                        tx_din_q      <= pick_data;
                        grant_id_q    <= pick_id;
                        grant_valid_q <= 1'b1;
                        lock_q        <= lock_next;
                        tx_wr_en_q    <= 1'b1;
                        req_ready_q   <= pick_onehot;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_ptr_q <= grant_id_q;
                    state_q  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_valid_q <= lock_q;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_din      = tx_din_q;
    assign tx_wr_en    = tx_wr_en_q;
    assign req_ready   = req_ready_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a queue-based rotation model
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [DW-1:0]        tx_din;
    logic                 tx_wr_en;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_din      (tx_din),
        .tx_wr_en    (tx_wr_en),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Simple uart_tx_v2 stand-in: busy for char_cyc cycles after each write, not reset by rst_n.
    int char_cyc   = 6;
    int busy_cnt   = 0;
    bit force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_wr_en) busy_cnt <= char_cyc;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt > 0);

    int errors = 0;
    int checks = 0;

    logic [7:0] qd [NUM_REQ][$];
    bit         ql [NUM_REQ][$];
    int         start_cyc [NUM_REQ];
    bit         arrived [NUM_REQ];
    int         arrive_grants [NUM_REQ];
    logic [7:0] line_q [$];
    int         served [$];
    int         cyc;
    int         issues;
    int         first_issue_cyc;
    int         m_ptr;
    int         m_owner;

    function automatic string line_hex();
        string s = "";
        foreach (line_q[i]) s = {s, $sformatf("%02h", line_q[i])};
        return s;
    endfunction

    function automatic bit line_is(input string s);
        if (line_q.size() != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) if (line_q[i] !== s[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Next requester in strict rotation after the last one served, restricted to the packet owner if any.
    function automatic int predict(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (v[idx] && (m_owner < 0 || m_owner == idx)) return idx;
        end
        return -1;
    endfunction

    task automatic add_byte(input int r, input logic [7:0] d, input bit l);
        qd[r].push_back(d);
        ql[r].push_back(l);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            qd[i].delete(); ql[i].delete();
            start_cyc[i] = 0; arrived[i] = 1'b0; arrive_grants[i] = 0;
        end
        line_q.delete(); served.delete();
        cyc = 0; issues = 0; m_ptr = NUM_REQ - 1; m_owner = -1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cyc >= start_cyc[i] && qd[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = qd[i][0];
                req_last[i]        = ql[i][0];
                if (!arrived[i]) begin
                    arrived[i] = 1'b1;
                    arrive_grants[i] = issues;
                end
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        int guard = 0;
        while (busy_cnt != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        clear_all();
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until all queues drain and the UART is idle (or max_issues writes), checking every write.
    task automatic run(input int budget, input int max_issues);
        int n = 0;
        bit done = 1'b0;
        bit timed_out = 1'b0;
        logic [NUM_REQ-1:0] valid_seen;
        first_issue_cyc = -1;
        while (!done) begin
            valid_seen = req_valid;
            @(negedge clk);
            cyc++; n++;
            if (tx_wr_en) begin
                int exp_id;
                logic [NUM_REQ-1:0] one;
                exp_id = predict(valid_seen);
                line_q.push_back(tx_din);
                if (first_issue_cyc < 0) first_issue_cyc = n;
                checks++;
                if (tx_busy !== 1'b0) begin
                    errors++; $display("FAIL wr_while_busy: tx_busy=%0b required 0", tx_busy);
                end
                checks++;
                if (exp_id < 0) begin
                    errors++; $display("FAIL unexpected_issue: grant_id=%0d required no write", grant_id);
                end else begin
                    one = 1; one = one << exp_id;
                    checks++;
                    if (grant_id !== IDW'(exp_id)) begin
                        errors++; $display("FAIL grant_id: got %0d required %0d", grant_id, exp_id);
                    end
                    checks++;
                    if (tx_din !== qd[exp_id][0]) begin
                        errors++; $display("FAIL tx_din: got %02h required %02h", tx_din, qd[exp_id][0]);
                    end
                    checks++;
                    if (req_ready !== one) begin
                        errors++; $display("FAIL req_ready: got %b required %b", req_ready, one);
                    end
                    checks++;
                    if (grant_valid !== 1'b1) begin
                        errors++; $display("FAIL grant_valid_issue: got %0b required 1", grant_valid);
                    end
                    m_ptr = exp_id;
`ifdef UART_ARB_PKT_LOCK_EN
                    m_owner = ql[exp_id][0] ? -1 : exp_id;
`endif
                    served.push_back(exp_id);
                    void'(qd[exp_id].pop_front());
                    void'(ql[exp_id].pop_front());
                end
                issues++;
            end else begin
                checks++;
                if (req_ready !== '0) begin
                    errors++; $display("FAIL stray_ready: got %b required 0", req_ready);
                end
            end
            drive_inputs();
            if (max_issues > 0 && issues >= max_issues) begin
                done = 1'b1;
            end else begin
                bit empty = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) if (qd[i].size() != 0) empty = 1'b0;
                if (empty && busy_cnt == 0 && !tx_wr_en) done = 1'b1;
            end
            if (!done && n >= budget) begin
                timed_out = 1'b1;
                done = 1'b1;
            end
        end
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL run_timeout: issues=%0d after %0d cycles required completion", issues, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (tx_wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %0b required 0", tx_wr_en); end
        checks++; if (req_ready !== '0)     begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready); end
        checks++; if (tx_din !== 8'h00)     begin errors++; $display("FAIL reset_din: got %02h required 00", tx_din); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gvalid: got %0b required 0", grant_valid); end
        checks++; if (grant_id !== '0)      begin errors++; $display("FAIL reset_gid: got %0d required 0", grant_id); end
    endtask

    task automatic test_single();
        do_reset();
        add_byte(0, 8'h41, 1'b1);
        drive_inputs();
        run(200, 0);
        checks++;
        if (first_issue_cyc !== 1) begin
            errors++; $display("FAIL single_latency: got %0d cycles required 1", first_issue_cyc);
        end
        checks++;
        if (!line_is("A")) begin
            errors++; $display("FAIL single_line: got %s required 41", line_hex());
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) add_byte(i, 8'h41 + 8'(i), 1'b1);
        drive_inputs();
        run(400, 0);
        checks++;
        if (!line_is("ABCD")) begin
            errors++; $display("FAIL contention_line: got %s required 41424344", line_hex());
        end
    endtask

    task automatic test_fairness();
        int pos = -1;
        do_reset();
        for (int j = 0; j < 10; j++) add_byte(1, 8'h60 + 8'(j), 1'b1);
        add_byte(2, 8'h5a, 1'b1);
        start_cyc[2] = 7;
        drive_inputs();
        run(1000, 0);
        foreach (served[i]) if (served[i] == 2 && pos < 0) pos = i;
        checks++;
        if (pos < 0 || (pos - arrive_grants[2] + 1) > 2) begin
            errors++; $display("FAIL fairness: req2 at grant %0d arrived after %0d grants, required within 2", pos, arrive_grants[2]);
        end
    endtask

    task automatic test_pkt_lock();
        do_reset();
        add_byte(0, 8'h48, 1'b0);
        add_byte(0, 8'h49, 1'b0);
        add_byte(0, 8'h0a, 1'b1);
        add_byte(1, 8'h58, 1'b1);
        drive_inputs();
        run(600, 0);
        checks++;
`ifdef UART_ARB_PKT_LOCK_EN
        if (!line_is("HI\nX")) begin
            errors++; $display("FAIL pkt_line: got %s required 48490a58", line_hex());
        end
`else
        if (!line_is("HXI\n")) begin
            errors++; $display("FAIL pkt_line: got %s required 4858490a", line_hex());
        end
`endif
    endtask

    task automatic test_busy_start();
        int early = 0;
        force_busy = 1'b1;
        do_reset();
        add_byte(0, 8'h42, 1'b1);
        drive_inputs();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_wr_en) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL busy_start_early: got %0d writes required 0", early);
        end
        force_busy = 1'b0;
        run(200, 0);
        checks++;
        if (first_issue_cyc !== 1) begin
            errors++; $display("FAIL busy_start_latency: got %0d cycles required 1", first_issue_cyc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        char_cyc = 12;
        add_byte(1, 8'h51, 1'b1);
        drive_inputs();
        run(200, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre: grant_valid=%0b tx_busy=%0b required 1/1", grant_valid, tx_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL mid_gvalid: got %0b required 0", grant_valid); end
        checks++; if (grant_id !== '0)      begin errors++; $display("FAIL mid_gid: got %0d required 0", grant_id); end
        checks++; if (tx_din !== 8'h00)     begin errors++; $display("FAIL mid_din: got %02h required 00", tx_din); end
        checks++; if (tx_wr_en !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL mid_strobes: wr_en=%0b ready=%b required 0", tx_wr_en, req_ready);
        end
        clear_all();
        add_byte(0, 8'h61, 1'b1);
        add_byte(1, 8'h62, 1'b1);
        add_byte(2, 8'h63, 1'b1);
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run(600, 0);
        checks++;
        if (served.size() == 0 || served[0] != 0) begin
            errors++; $display("FAIL mid_first: got %0d required requester 0", (served.size() == 0) ? -1 : served[0]);
        end
        checks++;
        if (!line_is("abc")) begin
            errors++; $display("FAIL mid_line: got %s required 616263", line_hex());
        end
        char_cyc = 6;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int total = 0;
            do_reset();
            char_cyc = $urandom_range(2, 8);
            for (int i = 0; i < NUM_REQ; i++) begin
                int n;
                n = $urandom_range(0, 4);
                start_cyc[i] = $urandom_range(0, 40);
                for (int j = 0; j < n; j++) begin
                    add_byte(i, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
                end
                total += n;
            end
            drive_inputs();
            run(3000, 0);
            checks++;
            if (line_q.size() != total) begin
                errors++; $display("FAIL random_count: iter %0d got %0d bytes required %0d", it, line_q.size(), total);
            end
        end
        char_cyc = 6;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clear_all();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_pkt_lock();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single `uart_tx_v2` serializer between several byte-stream requesters, e.g. the CPU debug console, the RAM loader echo and the bench self-check. Each requester offers bytes on a valid/ready port. The arbiter grants one requester, presents its byte to `uart_tx_v2` as a one-cycle `wr_en` pulse, and tracks `tx_busy` until the character has left the line. It sits between the requesters and `uart_tx_v2`, and owns `uart_tx_v2`'s `din`/`wr_en` inputs exclusively.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DW`, 8: byte width; fixed to 8, matching `uart_tx_v2`.

Ports:
- `clk`  in  1  single system clock; `uart_tx_v2` runs on the same clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*DW  bytes; requester i uses bits [i*8+7:i*8].
- `req_last`  in  NUM_REQ  marks the last byte of a packet; only used when `UART_ARB_PKT_LOCK_EN` is defined.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle byte-accepted pulse.
- `tx_din`  out  8  byte to `uart_tx_v2.din`.
- `tx_wr_en`  out  1  write strobe to `uart_tx_v2.wr_en`.
- `tx_busy`  in  1  from `uart_tx_v2.tx_busy`.
- `grant_valid`  out  1  a requester currently owns the UART.
- `grant_id`  out  $clog2(NUM_REQ)  index of the owning requester.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE, when `tx_busy`=0 and a candidate is valid:
  - Pick the winner round-robin, starting from `rr_ptr+1` modulo NUM_REQ.
  - Register `tx_din <= req_data[winner]`, `grant_id <= winner`, `grant_valid <= 1`; go to ISSUE.
- ISSUE, one cycle:
  - `tx_wr_en`=1 and `req_ready[grant_id]`=1.
  - `rr_ptr <= grant_id`.
  - Go to WAIT_ACK.
- WAIT_ACK: wait for `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy`=0, then go to IDLE and clear `grant_valid`, unless the packet lock holds it (see Configuration).
- Requester rule: `req_data` and `req_last` stay stable while `req_valid`=1 and `req_ready`=0. Deasserting `req_valid` before `req_ready` is legal; that byte is simply not sent.
- IDLE with `tx_busy`=1 (UART busy from before reset release): stay in IDLE and issue nothing.
- Simultaneous requests: exactly one grant per byte, in strict rotation. For example, with all requesters valid and `rr_ptr`=1, the order is 2, 3, 0, 1.
- A requester that asserts valid mid-transfer is considered at the next IDLE.
- `tx_din` holds its last value between issues; it is only updated on the IDLE→ISSUE transition.

## Timing
- Reset values: state=IDLE, `tx_din`=0, `tx_wr_en`=0, `req_ready`=0, `grant_valid`=0, `grant_id`=0, `rr_ptr`=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered, or decoded from state and grant registers only; there is no combinational path from `req_valid` to `req_ready`.
- `req_valid` first seen high in IDLE at cycle N gives `tx_wr_en` and `req_ready` at N+1, with `tx_din` valid from N+1.
- Back-to-back bytes: the next `tx_wr_en` comes no earlier than 2 cycles after `tx_busy` falls.
- `rst_n` low at any time returns all registers to reset values immediately. The byte in flight inside `uart_tx_v2` is not tracked; after reset the first issue waits for `tx_busy`=0.

## Configuration
- `UART_ARB_PKT_LOCK_EN` defined:
  - After a byte with `req_last`=0, WAIT_DONE returns to IDLE with `grant_valid` held.
  - Only `grant_id` is eligible until a byte with `req_last`=1 has been sent; other requesters wait, even if the owner drops valid.
  - This keeps multi-byte messages contiguous on the line.
- Undefined: re-arbitrate after every byte, ignore `req_last`, and clear `grant_valid` in every IDLE.

## Structure
- Package `uart_arb_pkg`:
  - `uart_arb_state_e` enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
  - `UART_ARB_MAX_REQ`=8.
  - Localparam helper for the `grant_id` width.
- Sub-module `uart_arb_rr`: combinational round-robin picker.
  - Inputs: `req` (NUM_REQ bits), `ptr`.
  - Outputs: `gnt_id`, `gnt_any`.
- When the packet lock is held, the FSM masks `req` down to `grant_id` before calling the picker.

## Test plan
- Single byte: requester 0 sends 0x41 after reset → `tx_wr_en` one cycle later with `tx_din`=0x41; `req_ready[0]` pulses once; the serial line carries 'A'.
- Contention: requesters 0–3 all valid with 0x41..0x44 → line carries "ABCD" in order; exactly one `req_ready` per byte; no `wr_en` while `tx_busy`=1.
- Fairness: requester 1 streams continuously while requester 2 sends one byte → requester 2's byte is issued within 2 grants.
- Packet lock (macro on): requester 0 sends "HI\n" with `last` on '\n' while requester 1 offers 'X' → line carries "HI\nX". With the macro off the same stimulus gives "HXI\n".
- Busy at start: hold `tx_busy`=1 for 50 cycles after reset with requester 0 valid → no `tx_wr_en` until 1 cycle after `tx_busy` falls.
- Reset mid-transfer: assert `rst_n`=0 in WAIT_DONE → all outputs return to reset values the same cycle; after release, requester 0 is served first.
